// File: rtl/case_pkg.sv
// Shared constants and types for the case-conversion stream arbiter.
package case_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_UPPER  = 2'b01,
    MODE_LOWER  = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_e;

  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_UP_LO = 8'h41;
  localparam logic [7:0] CH_UP_HI = 8'h5A;
  localparam logic [7:0] CH_LO_LO = 8'h61;
  localparam logic [7:0] CH_LO_HI = 8'h7A;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_e;

endpackage

// File: rtl/case_conv_unit.sv
// Combinational ASCII case converter: byte + mode -> byte + changed flag.
module case_conv_unit
  import case_pkg::*;
(
  input  logic [7:0] din,
  input  logic [1:0] mode,
  output logic [7:0] dout,
  output logic       changed
);

  logic is_up;
  logic is_lo;

  assign is_up = (din >= CH_UP_LO) && (din <= CH_UP_HI);
  assign is_lo = (din >= CH_LO_LO) && (din <= CH_LO_HI);

  // Only bit5 of a letter ever flips; everything else passes through.
  always_comb begin
    dout = din;
    case (mode)
      MODE_UPPER:  if (is_lo) dout[5] = 1'b0;
      MODE_LOWER:  if (is_up) dout[5] = 1'b1;
      MODE_TOGGLE: if (is_up || is_lo) dout[5] = ~din[5];
      default:     dout = din;
    endcase
  end

  assign changed = (dout != din);

endmodule

// File: rtl/case_stream_arbiter.sv
// Two-requester round-robin arbiter with line locking feeding one shared
// case converter and a single registered valid/ready output stage.
//
// state | meaning
// IDLE  | no lock; round-robin between valid requesters
// LOCK0 | requester 0 owns the datapath until newline, burst limit or drop
// LOCK1 | requester 1 owns the datapath until newline, burst limit or drop
module case_stream_arbiter
  import case_pkg::*;
#(
  parameter int BURST_MAX = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  input  logic [1:0]       req0_mode,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  input  logic [1:0]       req1_mode,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_id,
  input  logic             out_ready,
  output logic [CNT_W-1:0] conv_count,
  output logic             busy
);

  localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

  state_e     state, state_nxt;
  logic       last_grant, last_grant_nxt;
  logic [7:0] burst_cnt, burst_cnt_nxt;
  logic [7:0] burst_inc;
  logic       grant0, grant1;
  logic       can_accept;
  logic       acc0, acc1, accept;
  logic       sel_id;
  logic [7:0] sel_data;
  logic [1:0] sel_mode;
  logic [7:0] conv_data;
  logic       conv_changed;
  logic       lock_id;
  logic       lock_valid;

  // Grant: round-robin in IDLE (last_grant loses ties), fixed while locked.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          grant0 = last_grant;
          grant1 = !last_grant;
        end else begin
          grant0 = req0_valid;
          grant1 = req1_valid;
        end
      end
      LOCK0:   grant0 = 1'b1;
      LOCK1:   grant1 = 1'b1;
      default: ;
    endcase
  end

  assign can_accept = !out_valid || out_ready;
  assign req0_ready = grant0 && can_accept && !rst;
  assign req1_ready = grant1 && can_accept && !rst;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign accept     = acc0 || acc1;
  assign sel_id     = acc1;
  assign sel_data   = sel_id ? req1_data : req0_data;
  assign sel_mode   = sel_id ? req1_mode : req0_mode;

  case_conv_unit u_conv (
    .din     (sel_data),
    .mode    (sel_mode),
    .dout    (conv_data),
    .changed (conv_changed)
  );

  assign lock_id    = (state == LOCK1);
  assign lock_valid = lock_id ? req1_valid : req0_valid;
  assign burst_inc  = burst_cnt + 8'd1;

  // Next-state: enter lock on a non-newline accept, release on newline,
  // burst limit or the owner dropping valid.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    burst_cnt_nxt  = burst_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (sel_data == CH_NL) begin
            last_grant_nxt = sel_id;
          end else begin
            state_nxt     = sel_id ? LOCK1 : LOCK0;
            burst_cnt_nxt = 8'd1;
          end
        end
      end
      LOCK0, LOCK1: begin
        if (!lock_valid) begin
          state_nxt      = IDLE;
          last_grant_nxt = lock_id;
          burst_cnt_nxt  = 8'd0;
        end else if (accept) begin
          burst_cnt_nxt = burst_inc;
          if (sel_data == CH_NL || burst_inc == BURST_LIM) begin
            state_nxt      = IDLE;
            last_grant_nxt = lock_id;
            burst_cnt_nxt  = 8'd0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register; last_grant resets to 1 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      burst_cnt  <= 8'd0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  // Output register: load on accept, clear only when drained without refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_id    <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= conv_data;
      out_id    <= sel_id;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of accepted bytes whose value was modified.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_count <= '0;
    end else if (accept && conv_changed && (conv_count != '1)) begin
      conv_count <= conv_count + CNT_W'(1);
    end
  end

  assign busy = (state != IDLE) || out_valid;

endmodule

// File: tb/tb_case_stream_arbiter.sv
// Scoreboard bench: each test pushes the expected output stream, per-requester
// byte queues drive the inputs, and a monitor pops/compares on each transfer.
module tb_case_stream_arbiter;
  import case_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic [1:0] req0_mode = 2'b00, req1_mode = 2'b00;
  logic       req0_ready, req1_ready;
  logic       out_valid, out_id, busy;
  logic [7:0] out_data;
  logic       out_ready = 1'b1;
  logic [15:0] conv_count;

  logic       s_req0_ready, s_req1_ready, s_out_valid, s_out_id, s_busy;
  logic [7:0] s_out_data;
  logic [3:0] s_conv_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] src0[$];
  logic [7:0] src1[$];
  logic [8:0] exp_q[$];
  logic       acc0_s = 1'b0, acc1_s = 1'b0;

  always #5 clk = ~clk;

  case_stream_arbiter #(.BURST_MAX(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_mode(req0_mode), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_mode(req1_mode), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_ready(out_ready),
    .conv_count(conv_count), .busy(busy)
  );

  case_stream_arbiter #(.BURST_MAX(16), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_mode(req0_mode), .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_mode(req1_mode), .req1_ready(s_req1_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_id(s_out_id), .out_ready(out_ready),
    .conv_count(s_conv_count), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, expv, $time);
    end
  endtask

  // Monitor: sample handshakes mid-cycle; compare each output transfer.
  always @(negedge clk) begin
    logic [8:0] e;
    acc0_s = req0_valid && req0_ready;
    acc1_s = req1_valid && req1_ready;
    if (out_valid && out_ready) begin
      chk("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_id_data", {23'd0, out_id, out_data}, {23'd0, e});
      end
    end
  end

  // Driver: retire accepted bytes and present the next one after each edge.
  always @(posedge clk) begin
    logic [7:0] d;
    #1;
    if (acc0_s && src0.size() > 0) d = src0.pop_front();
    if (acc1_s && src1.size() > 0) d = src1.pop_front();
    req0_valid = (src0.size() > 0);
    req0_data  = (src0.size() > 0) ? src0[0] : 8'h00;
    req1_valid = (src1.size() > 0);
    req1_data  = (src1.size() > 0) ? src1[0] : 8'h00;
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    out_ready = 1'b1;
    src0.delete(); src1.delete(); exp_q.delete();
    @(posedge clk); @(posedge clk); #2;
  endtask

  task automatic release_rst();
    @(posedge clk); #2;
    chk("rdy0_in_rst", {31'd0, req0_ready}, 32'd0);
    chk("rdy1_in_rst", {31'd0, req1_ready}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((src0.size() > 0 || src1.size() > 0 || exp_q.size() > 0 || out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size() + src0.size() + src1.size(), 32'd0);
  endtask

  task automatic push_exp(input logic id, input logic [7:0] b);
    exp_q.push_back({id, b});
  endtask

  initial begin
    // Test 1: reset state, "aB1" upper on req0
    do_reset();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_id", {31'd0, out_id}, 32'd0);
    chk("rst_conv_count", {16'd0, conv_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    req0_mode = MODE_UPPER;
    src0 = '{8'h61, 8'h42, 8'h31};
    push_exp(1'b0, 8'h41); push_exp(1'b0, 8'h42); push_exp(1'b0, 8'h31);
    release_rst();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_lock0", {30'd0, dut.state}, {30'd0, LOCK0});
    end
    chk("t1_count", {16'd0, conv_count}, 32'd1);
    chk("t1_busy_hi", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("t1_busy_lo", {31'd0, busy}, 32'd0);
    chk("t1_idle", {30'd0, dut.state}, {30'd0, IDLE});
    wait_drain(20);

    // Test 2: both requesters with lines; no interleave
    do_reset();
    req0_mode = MODE_UPPER; req1_mode = MODE_LOWER;
    src0 = '{8'h68, 8'h69, 8'h0A};
    src1 = '{8'h6F, 8'h6B, 8'h0A};
    push_exp(1'b0, 8'h48); push_exp(1'b0, 8'h49); push_exp(1'b0, 8'h0A);
    push_exp(1'b1, 8'h6F); push_exp(1'b1, 8'h6B); push_exp(1'b1, 8'h0A);
    release_rst();
    wait_drain(40);
    chk("t2_count", {16'd0, conv_count}, 32'd2);

    // Test 3: backpressure holds exactly one byte, then 1/cycle
    do_reset();
    out_ready = 1'b0;
    req0_mode = MODE_PASS;
    src0 = '{8'h61, 8'h62, 8'h63, 8'h64};
    push_exp(1'b0, 8'h61); push_exp(1'b0, 8'h62); push_exp(1'b0, 8'h63); push_exp(1'b0, 8'h64);
    release_rst();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_hold_data", {24'd0, out_data}, 32'h61);
      chk("t3_hold_rdy", {31'd0, req0_ready}, 32'd0);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_flow_valid", {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    chk("t3_flow_end", {31'd0, out_valid}, 32'd0);
    wait_drain(20);

    // Test 4: burst limit forces release to req1 for one byte
    do_reset();
    req0_mode = MODE_PASS; req1_mode = MODE_PASS;
    for (int i = 0; i < 20; i++) src0.push_back(8'h78);
    src1.push_back(8'h79);
    for (int i = 0; i < 16; i++) push_exp(1'b0, 8'h78);
    push_exp(1'b1, 8'h79);
    for (int i = 0; i < 4; i++) push_exp(1'b0, 8'h78);
    release_rst();
    wait_drain(80);

    // Test 5: toggle on boundary characters via req1
    do_reset();
    req1_mode = MODE_TOGGLE;
    src1 = '{8'h7A, 8'h5B, 8'h40, 8'h41};
    push_exp(1'b1, 8'h5A); push_exp(1'b1, 8'h5B); push_exp(1'b1, 8'h40); push_exp(1'b1, 8'h61);
    release_rst();
    wait_drain(30);
    chk("t5_count", {16'd0, conv_count}, 32'd2);

    // Test 6: counter saturation on the 4-bit instance
    do_reset();
    req0_mode = MODE_UPPER;
    for (int i = 0; i < 20; i++) begin
      src0.push_back(8'h61);
      push_exp(1'b0, 8'h41);
    end
    release_rst();
    wait_drain(80);
    chk("t6_count16", {16'd0, conv_count}, 32'd20);
    chk("t6_count4_sat", {28'd0, s_conv_count}, 32'd15);

    // Test 7: reset mid-burst with a pending output byte
    do_reset();
    req0_mode = MODE_PASS; req1_mode = MODE_PASS;
    src0 = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
    release_rst();
    @(negedge clk);
    @(posedge clk); #2;
    chk("t7_pre_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t7_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t7_rst_state", {30'd0, dut.state}, {30'd0, IDLE});
    src0.delete(); src1.delete(); exp_q.delete();
    @(posedge clk); #2;
    src0 = '{8'h70, 8'h0A};
    src1 = '{8'h71, 8'h0A};
    push_exp(1'b0, 8'h70); push_exp(1'b0, 8'h0A);
    push_exp(1'b1, 8'h71); push_exp(1'b1, 8'h0A);
    release_rst();
    @(negedge clk);
    chk("t7_grant0", {31'd0, req0_ready}, 32'd1);
    chk("t7_nogrant1", {31'd0, req1_ready}, 32'd0);
    wait_drain(40);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/case_stream_arbiter.md
Name: case_stream_arbiter

Overview:
- Shares one ASCII case-conversion datapath between two byte-stream requesters (e.g. UART RX path and a host write path).
- Arbitrates round-robin, holds the grant for a line (a burst ending in newline) so text lines never interleave, and converts each byte per the requester's mode.
- Presents the result through a registered valid/ready output tagged with the source ID.
- Counts bytes actually modified.

Parameters:
- BURST_MAX, 16, maximum bytes per locked burst before forced release (legal range 2..255)
- CNT_W, 16, width of the modified-byte counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req0_valid  in  1  requester 0 byte available
- req0_data  in  8  requester 0 ASCII byte
- req0_mode  in  2  requester 0 mode: 00 pass, 01 upper, 10 lower, 11 toggle
- req0_ready  out  1  requester 0 byte accepted this cycle when valid&ready
- req1_valid, req1_data, req1_mode, req1_ready  same as requester 0, for requester 1
- out_valid  out  1  converted byte held in output register
- out_data  out  8  converted byte
- out_id  out  1  source requester of out_data
- out_ready  in  1  downstream accepts when out_valid&out_ready
- conv_count  out  CNT_W  number of accepted bytes whose value changed, saturating
- busy  out  1  FSM not IDLE or out_valid=1

Behaviour:
- Reset (async, active-high): out_valid=0, out_data=0x00, out_id=0, conv_count=0, state=IDLE, last_grant=1 (requester 0 wins first), burst_cnt=0; all readys 0 while rst=1.
- Capacity: single output register.
  - can_accept = !out_valid | out_ready.
  - At most one input byte accepted per cycle.
  - Latency 1 cycle from accept to out_valid.
  - Full throughput (1 byte/cycle) when out_ready is held high.
- Grant selection (combinational, no extra latency):
  - IDLE: if only one valid, grant it; if both valid, grant !last_grant.
  - LOCK_r: grant only r.
  - reqX_ready = grant_X & can_accept & !rst. Ready may depend on valid.
- Conversion on the accepted byte, using that requester's mode sampled in the same cycle:
  - Letters are 0x41-0x5A and 0x61-0x7A.
  - upper: a lowercase letter has bit5 cleared.
  - lower: an uppercase letter has bit5 set.
  - toggle: any letter has bit5 inverted.
  - pass, and all non-letters in every mode: byte unchanged.
- conv_count: +1 on each accept where converted != input; holds at 2^CNT_W-1.
- FSM states: IDLE, LOCK0, LOCK1.
  - IDLE -> LOCK_r: on accept from r with byte != 0x0A; burst_cnt=1.
  - IDLE stays IDLE: on accept of 0x0A (single-byte line); last_grant=r.
  - LOCK_r on accept: burst_cnt+1. If byte==0x0A or burst_cnt+1==BURST_MAX -> IDLE, last_grant=r.
  - LOCK_r with req_r_valid=0 in any cycle -> IDLE, last_grant=r; the other requester may be granted on the following cycle.
  - LOCK_r with req_r_valid=1 but can_accept=0: stay, no count change.
- Output register:
  - Loads {converted, id} and sets out_valid on accept.
  - Clears out_valid when drained with no accept in the same cycle.
  - Simultaneous drain and accept: load the new byte; out_valid stays 1.
  - out_data/out_id are stable while out_valid & !out_ready.
- Reset asserted mid-burst or with out_valid=1: the pending byte is dropped; return to the reset state immediately.

Decomposition:
- Shared package case_pkg:
  - mode encodings MODE_PASS/UPPER/LOWER/TOGGLE
  - ASCII constants CH_NL=0x0A, upper range 0x41-0x5A, lower range 0x61-0x7A
  - FSM state enum
- One sub-module: case_conv_unit, a purely combinational byte+mode -> byte+changed flag. It is reused standalone elsewhere.
- Arbiter FSM, output register and counter stay in the top.

Test Plan:
- Reset, then req0 sends "aB1" mode=01 with out_ready=1:
  - outputs 0x41,0x42,0x31 on consecutive cycles, id=0;
  - conv_count=1;
  - FSM stays LOCK0 through all three bytes;
  - busy deasserts after req0 drops valid and the last byte drains.
- Both requesters valid from reset:
  - req0="hi\n" mode 01, req1="ok\n" mode 10;
  - output "HI\n" all with id=0, then "ok\n" all with id=1, no interleave.
- Backpressure: out_ready=0 for 5 cycles with req0 valid:
  - exactly one byte held, out_data stable;
  - req0_ready=0 after the first accept;
  - release -> remaining bytes flow 1/cycle.
- BURST_MAX=16 with req0 streaming 20 'x' bytes (no newline) and req1 valid:
  - after 16 req0 bytes, one req1 byte granted (id=1);
  - the next burst then goes to req0 after req1's lock ends.
- Modes on 0x7A,0x5B,0x40,0x41 with toggle:
  - outputs 0x5A,0x5B,0x40,0x61;
  - conv_count +2.
- Saturation (CNT_W=4): 20 changing bytes -> conv_count=15.
- Assert rst mid-burst with out_valid=1:
  - out_valid=0 and state=IDLE immediately;
  - the next grant goes to req0.
